result_reader: RTL



---
 rtl/result_reader_pkg.sv | 22 ++
 rtl/result_reader_if.sv | 29 ++
 rtl/result_reader_lane_select.sv | 20 ++
 rtl/result_reader.sv | 121 ++++++++++++
 4 files changed

// File: rtl/result_reader_pkg.sv
// Shared constants and state encoding for the result reader.
// LANES/LANE_W match the product register file; the FSM encoding is fixed
// so that other blocks and debug tooling can decode the state.
package result_reader_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned IDX_W  = $clog2(LANES);
    localparam int unsigned VEC_W  = LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // True when idx addresses the final lane of the vector.
    function automatic logic is_last_lane(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(LANES - 1);
    endfunction

endpackage

// File: rtl/result_reader_if.sv
// Byte-stream interface from the result reader to its consumer.
//   out_data  : current lane byte
//   out_idx   : lane index of out_data
//   out_valid : out_data/out_idx are valid
//   out_ready : consumer accepts the byte this cycle
// master = producer (result_reader), slave = consumer.
interface result_reader_if;
    import result_reader_pkg::*;

    logic [LANE_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/result_reader_lane_select.sv
// Lane multiplexer: picks one byte lane out of the packed snapshot.
//   snapshot : packed vector, lane k at [k*LANE_W +: LANE_W]
//   idx      : lane to select
//   lane_c   : selected lane (combinational)
module result_reader_lane_select
    import result_reader_pkg::*;
(
    input  logic [VEC_W-1:0]  snapshot,
    input  logic [IDX_W-1:0]  idx,
    output logic [LANE_W-1:0] lane_c
);

    logic [LANES-1:0][LANE_W-1:0] lanes;

    always_comb begin
        lanes  = snapshot;
        lane_c = lanes[idx];
    end

endmodule

// File: rtl/result_reader.sv
// Snapshots the packed 64-bit result vector on start and streams it out one
// lane per valid/ready handshake, lane 0 first.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a transaction (honoured only in IDLE)
//   flush        : synchronous abort back to IDLE (beats start and handshakes)
//   contents     : packed vector to snapshot
//   out_if       : byte stream (out_data/out_idx/out_valid/out_ready)
//   busy         : high from start acceptance until the done pulse
//   done         : one-cycle pulse after the final lane is accepted
module result_reader
    import result_reader_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               flush,
    input  logic [VEC_W-1:0]   contents,
    result_reader_if.master    out_if,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               busy_d;
    logic               done_d;
    logic               hs_c;
    logic [LANE_W-1:0]  lane_c;

    assign hs_c = valid_q & out_if.out_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic; every output is loaded into a flop.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_d = ST_STREAM;
                    snap_d  = contents;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_STREAM: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (hs_c) begin
                    if (is_last_lane(idx_q)) begin
                        // Last lane taken: drop valid/busy and fire done together.
                        state_d = ST_FINISH;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // out_data is a mux of two flops, so out_ready never reaches it.
    result_reader_lane_select u_lane_select (
        .snapshot (snap_q),
        .idx      (idx_q),
        .lane_c   (lane_c)
    );

    assign out_if.out_data  = lane_c;
    assign out_if.out_idx   = idx_q;
    assign out_if.out_valid = valid_q;

endmodule
